// File: rtl/router_output_arbiter.sv
// router_output_arbiter
// Per-output-port packet arbiter. Round-robin over packets: a requester keeps
// the link from head flit to tail flit. A stall watchdog drops a grant that
// sees no handshake for LOCK_TIMEOUT cycles, so a dead neighbour cannot hold
// the link forever. NUM_REQ must be at least 2; LOCK_TIMEOUT = 0 disables
// the watchdog.
module router_output_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_tail,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       timeout
);

    localparam int SEL_W = $clog2(NUM_REQ);
    // One extra bit so (last + offset) cannot overflow before the wrap.
    localparam int SUM_W = SEL_W + 1;
    // A disabled watchdog still needs a legal (1-bit) counter width.
    localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    localparam logic [SUM_W-1:0] NUM_REQ_S  = SUM_W'(NUM_REQ);
    localparam logic [SEL_W-1:0] LAST_RESET = SEL_W'(NUM_REQ - 1);
    localparam bit               WD_EN      = (LOCK_TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_FIRE   = WD_EN ? CNT_W'(LOCK_TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q,   state_d;
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic [SEL_W-1:0]   sel_q,     sel_d;
    logic [SEL_W-1:0]   last_q,    last_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               timeout_q, timeout_d;

    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic [SUM_W-1:0]   rr_sum;
    logic               hs;
    logic               tail_sel;
    logic               wd_fire;

    // Output-side handshake: gated only by the registered one-hot grant, which
    // is all-zero in IDLE, so no state decode sits in this path.
    assign out_valid = |(grant_q & req_valid);
    assign req_ready = grant_q & req_valid & {NUM_REQ{out_ready}};

    assign hs       = out_valid & out_ready;
    assign tail_sel = req_tail[sel_q];
    assign wd_fire  = WD_EN && (cnt_q == CNT_FIRE) && !hs;

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = (state_q == LOCKED);
    assign timeout = timeout_q;

    // Round-robin scan: first valid requester starting at (last + 1), wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        rr_sum     = '0;
        // NOTE: blocking assignments here because rr_sum is a scratch value
        // recomputed and consumed within the same loop iteration.
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_sum = {1'b0, last_q} + SUM_W'(i);
            if (rr_sum >= NUM_REQ_S) begin
                rr_sum = rr_sum - NUM_REQ_S;
            end
            if (!pick_found && req_valid[rr_sum[SEL_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = rr_sum[SEL_W-1:0];
            end
        end
    end

    // Next-state logic for the IDLE/LOCKED controller, stall counter and watchdog.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    state_d           = LOCKED;
                    grant_d[pick_idx] = 1'b1;
                    sel_d             = pick_idx;
                    last_d            = pick_idx;
                    cnt_d             = '0;
                end
            end

            LOCKED: begin
                if (hs && tail_sel) begin
                    // Packet complete: release the link for the next arbitration.
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (hs) begin
                    cnt_d = '0;
                end else if (wd_fire) begin
                    // Stalled too long: drop the grant. last keeps the dropped
                    // index so that requester ranks lowest next time.
                    state_d   = IDLE;
                    grant_d   = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; port 0 gets first priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            last_q    <= LAST_RESET;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter (NUM_REQ = 4, LOCK_TIMEOUT = 8).
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_router_output_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int LOCK_TIMEOUT = 8;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_tail;
    logic [3:0]   req_ready;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;

    router_output_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_tail  (req_tail),
        .req_ready (req_ready),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] rr_exp [8];
        rr_exp = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

        // Reset
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_tail  = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_grant",     32'(grant),     32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_sel",       32'(sel),       32'h0);
        check("rst_timeout",   32'(timeout),   32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);

        // First grant: port 0 has priority after reset
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_tail  = 4'b1111;
        out_ready = 1'b1;
        tick();
        check("first_grant",     32'(grant),     32'h1);
        check("first_sel",       32'(sel),       32'h0);
        check("first_busy",      32'(busy),      32'h1);
        check("first_out_valid", 32'(out_valid), 32'h1);
        check("first_req_ready", 32'(req_ready), 32'h1);

        // Round-robin over single-flit packets, IDLE cycle between each
        tick();
        check("rr_idle0", 32'(grant), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rr_step%0d", i), 32'(grant), 32'(rr_exp[i]));
        end
        req_valid = 4'b0000;
        tick();
        check("rr_quiet", 32'(busy), 32'h0);

        // Packet lock: 3-flit packet from port 0 while port 2 waits (last = 0)
        req_valid = 4'b0001;
        req_tail  = 4'b0000;
        tick();
        check("lock_grant", 32'(grant), 32'h1);
        req_valid = 4'b0101;
        settle();
        check("lock_ready_only_p0", 32'(req_ready), 32'h1);
        tick();
        check("lock_flit1", 32'(grant), 32'h1);
        tick();
        check("lock_flit2", 32'(grant), 32'h1);
        req_tail = 4'b0001;
        tick();
        check("lock_tail_idle", 32'(grant), 32'h0);
        req_valid = 4'b0100;
        req_tail  = 4'b0000;
        tick();
        check("lock_next_grant", 32'(grant), 32'h4);
        check("lock_next_sel",   32'(sel),   32'h2);

        // Backpressure mid-packet on port 2
        tick();
        out_ready = 1'b0;
        settle();
        check("bp_req_ready0", 32'(req_ready), 32'h0);
        check("bp_out_valid",  32'(out_valid), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_hold%0d", i), 32'(grant), 32'h4);
            check($sformatf("bp_nowd%0d", i), 32'(timeout), 32'h0);
        end
        out_ready = 1'b1;
        req_tail  = 4'b0100;
        settle();
        check("bp_release_ready", 32'(req_ready), 32'h4);
        tick();
        check("bp_done_grant", 32'(grant), 32'h0);

        // Watchdog: port 1 granted (last = 2), then goes silent; port 3 waits
        req_valid = 4'b0010;
        req_tail  = 4'b0000;
        tick();
        check("wd_grant", 32'(grant), 32'h2);
        req_valid = 4'b1000;
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("wd_wait%0d", i), 32'(timeout), 32'h0);
            check($sformatf("wd_held%0d", i), 32'(grant),   32'h2);
        end
        tick();
        check("wd_pulse",      32'(timeout), 32'h1);
        check("wd_busy_low",   32'(busy),    32'h0);
        check("wd_grant_drop", 32'(grant),   32'h0);
        tick();
        check("wd_pulse_end",  32'(timeout), 32'h0);
        check("wd_next_grant", 32'(grant),   32'h8);
        check("wd_next_sel",   32'(sel),     32'h3);

        // Tail handshake in the watchdog firing cycle: no pulse
        out_ready = 1'b0;
        req_tail  = 4'b1000;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check("wdt_still_locked", 32'(grant), 32'h8);
        out_ready = 1'b1;
        tick();
        check("wdt_no_pulse", 32'(timeout), 32'h0);
        check("wdt_released", 32'(busy),    32'h0);
        req_valid = 4'b0000;
        req_tail  = 4'b0000;
        tick();
        check("wdt_no_pulse_late", 32'(timeout), 32'h0);

        // Reset mid-packet: port 0 locked (last = 0), reset restores last = 3
        req_valid = 4'b0001;
        tick();
        check("rmp_grant", 32'(grant), 32'h1);
        tick();
        check("rmp_flit1", 32'(grant), 32'h1);
        rst_n = 1'b0;
        tick();
        check("rmp_grant_clr", 32'(grant),     32'h0);
        check("rmp_busy_clr",  32'(busy),      32'h0);
        check("rmp_ready_clr", 32'(req_ready), 32'h0);
        rst_n     = 1'b1;
        req_valid = 4'b0011;
        tick();
        check("rmp_regrant", 32'(grant), 32'h1);
        check("rmp_sel",     32'(sel),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: observed no end of test, required end before 100000 ns");
        $fatal(1, "simulation time limit reached");
    end

endmodule
